// File: rtl/sha256_miner_pkg.sv
// sha256_miner_pkg: shared types and constants for the double-SHA256 nonce search.
// FSM state encoding, SHA256 initial hash value, padding tails and the
// message-block builders used when driving the shared compression core.
package sha256_miner_pkg;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_H1_ISSUE = 3'd1,
      S_H1_WAIT  = 3'd2,
      S_H2_ISSUE = 3'd3,
      S_H2_WAIT  = 3'd4,
      S_CHECK    = 3'd5
   } miner_state_e;

   // SHA256 initial hash value H0..H7, H0 in the most significant word.
   localparam logic [255:0] SHA256_IV = {
      32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
   };

   // Padding for an 80-byte (640-bit) header: marker bit, zeros, bit length.
   localparam logic [383:0] PAD_640 = {1'b1, 319'b0, 64'd640};

   // Padding for a 32-byte (256-bit) digest: marker bit, zeros, bit length.
   localparam logic [255:0] PAD_256 = {1'b1, 191'b0, 64'd256};

   // Second header block: last 12 header bytes, nonce, padding. MSB first, no byte swap.
   function automatic logic [511:0] block1_f(input logic [95:0] tail, input logic [31:0] nonce);
      return {tail, nonce, PAD_640};
   endfunction

   // Single block hashing the first-round digest.
   function automatic logic [511:0] block2_f(input logic [255:0] hash1);
      return {hash1, PAD_256};
   endfunction

endpackage

// File: rtl/sha256_miner_if.sv
// sha256_miner_if: bus between the miner controller (master) and the shared
// sha256 compression core (slave).
// Handshake: core_start is a one-cycle request; core_chain and core_block are
// held stable by the master from the core_start cycle until the cycle in which
// the core returns its one-cycle core_done pulse, with core_digest valid in that
// same cycle. There is no back-pressure; the master never issues a new
// core_start while a request is outstanding.
interface sha256_miner_if;

   logic         core_start;
   logic [255:0] core_chain;
   logic [511:0] core_block;
   logic         core_done;
   logic [255:0] core_digest;

   modport master (
      output core_start, core_chain, core_block,
      input  core_done, core_digest
   );

   modport slave (
      input  core_start, core_chain, core_block,
      output core_done, core_digest
   );

endinterface

// File: rtl/sha256_miner_cmp.sv
// sha256_miner_cmp: registered 256-bit unsigned a <= b comparator. The wide
// compare gets a full cycle on its own; le updates only when en is high.
module sha256_miner_cmp (
   input  logic         clk,
   input  logic         reset,
   input  logic         en,
   input  logic [255:0] a,
   input  logic [255:0] b,
   output logic         le
);

   // Capture the comparison result on the enable strobe.
   always_ff @(posedge clk) begin
      if (reset) begin
         le <= 1'b0;
      end else if (en) begin
         le <= (a <= b);
      end
   end

endmodule

// File: rtl/sha256_miner_ctrl.sv
// sha256_miner_ctrl: sequences one shared sha256 core through a double-SHA256
// nonce search: hash1 = compress(midstate, block1), hash2 = compress(IV, block2),
// hit when hash2 <= target. Optional feature macro MINER_HASH_CNT_EN adds the
// hash_cnt output counting completed CHECK evaluations (saturating).
module sha256_miner_ctrl
   import sha256_miner_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 256,
   parameter int TW             = 9
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic          abort,
   input  logic [255:0]  midstate,
   input  logic [95:0]   header_tail,
   input  logic [31:0]   nonce_start,
   input  logic [31:0]   nonce_end,
   input  logic [255:0]  target,
   sha256_miner_if.master core,
   output logic          busy,
   output logic          done,
   output logic          found,
   output logic [31:0]   found_nonce,
   output logic          error,
`ifdef MINER_HASH_CNT_EN
   output logic [47:0]   hash_cnt,
`endif
   output logic [2:0]    state_dbg
);

   localparam logic [2:0] ST_IDLE     = S_IDLE;
   localparam logic [2:0] ST_H1_ISSUE = S_H1_ISSUE;
   localparam logic [2:0] ST_H1_WAIT  = S_H1_WAIT;
   localparam logic [2:0] ST_H2_ISSUE = S_H2_ISSUE;
   localparam logic [2:0] ST_H2_WAIT  = S_H2_WAIT;
   localparam logic [2:0] ST_CHECK    = S_CHECK;

   logic [2:0]    state;
   logic [255:0]  midstate_q;
   logic [95:0]   tail_q;
   logic [31:0]   nonce_q;
   logic [31:0]   end_q;
   logic [255:0]  target_q;
   logic [255:0]  hash1_q;
   logic [TW-1:0] tcnt;
   logic          timeout_hit;
   logic          cmp_en;
   logic          hash_le;

   assign busy        = (state != ST_IDLE);
   assign state_dbg   = state;
   // tcnt equals the number of cycles elapsed since the last core_start.
   assign timeout_hit = (tcnt == TW'(TIMEOUT_CYCLES - 1));
   // The second digest goes straight into the registered comparator; an abort
   // in the same cycle wins, so no compare is launched then.
   assign cmp_en      = (state == ST_H2_WAIT) && core.core_done && !abort;

   sha256_miner_cmp u_cmp (
      .clk   (clk),
      .reset (reset),
      .en    (cmp_en),
      .a     (core.core_digest),
      .b     (target_q),
      .le    (hash_le)
   );

   // Core inputs follow the phase; they hold from core_start until core_done.
   always_comb begin
      core.core_start = 1'b0;
      core.core_chain = SHA256_IV;
      core.core_block = '0;
      case (state)
         ST_H1_ISSUE, ST_H1_WAIT: begin
            core.core_chain = midstate_q;
            core.core_block = block1_f(tail_q, nonce_q);
         end
         ST_H2_ISSUE, ST_H2_WAIT: begin
            core.core_chain = SHA256_IV;
            core.core_block = block2_f(hash1_q);
         end
         default: ;
      endcase
      if (state == ST_H1_ISSUE || state == ST_H2_ISSUE) core.core_start = 1'b1;
   end

   // Search FSM: abort wins over everything while busy; done is a one-cycle pulse.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= ST_IDLE;
         midstate_q  <= '0;
         tail_q      <= '0;
         nonce_q     <= '0;
         end_q       <= '0;
         target_q    <= '0;
         hash1_q     <= '0;
         tcnt        <= '0;
         done        <= 1'b0;
         found       <= 1'b0;
         found_nonce <= '0;
         error       <= 1'b0;
      end else begin
         done <= 1'b0;
         if (abort && state != ST_IDLE) begin
            done  <= 1'b1;
            found <= 1'b0;
            state <= ST_IDLE;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (start) begin
                     midstate_q  <= midstate;
                     tail_q      <= header_tail;
                     nonce_q     <= nonce_start;
                     end_q       <= nonce_end;
                     target_q    <= target;
                     found       <= 1'b0;
                     found_nonce <= '0;
                     error       <= 1'b0;
                     state       <= ST_H1_ISSUE;
                  end
               end
               ST_H1_ISSUE: begin
                  tcnt  <= TW'(1);
                  state <= ST_H1_WAIT;
               end
               ST_H1_WAIT: begin
                  tcnt <= tcnt + TW'(1);
                  if (core.core_done) begin
                     hash1_q <= core.core_digest;
                     state   <= ST_H2_ISSUE;
                  end else if (timeout_hit) begin
                     error <= 1'b1;
                     done  <= 1'b1;
                     state <= ST_IDLE;
                  end
               end
               ST_H2_ISSUE: begin
                  tcnt  <= TW'(1);
                  state <= ST_H2_WAIT;
               end
               ST_H2_WAIT: begin
                  tcnt <= tcnt + TW'(1);
                  if (core.core_done) begin
                     state <= ST_CHECK;
                  end else if (timeout_hit) begin
                     error <= 1'b1;
                     done  <= 1'b1;
                     state <= ST_IDLE;
                  end
               end
               ST_CHECK: begin
                  if (hash_le) begin
                     found       <= 1'b1;
                     found_nonce <= nonce_q;
                     done        <= 1'b1;
                     state       <= ST_IDLE;
                  end else if (nonce_q == end_q) begin
                     done  <= 1'b1;
                     state <= ST_IDLE;
                  end else begin
                     nonce_q <= nonce_q + 32'd1;
                     state   <= ST_H1_ISSUE;
                  end
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

`ifdef MINER_HASH_CNT_EN
   // Count completed CHECK evaluations, saturating; cleared by an accepted start.
   always_ff @(posedge clk) begin
      if (reset) begin
         hash_cnt <= '0;
      end else if (state == ST_IDLE && start) begin
         hash_cnt <= '0;
      end else if (state == ST_CHECK && !abort && hash_cnt != '1) begin
         hash_cnt <= hash_cnt + 48'd1;
      end
   end
`endif

endmodule

// File: tb/tb_sha256_miner_ctrl.sv
// tb_sha256_miner_ctrl: directed bench for sha256_miner_ctrl with a behavioural
// sha256 core model of programmable latency.
`timescale 1ns/1ps
module tb_sha256_miner_ctrl;

   localparam logic [255:0] IV_C = {
      32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
   };
   localparam logic [255:0] MS_C   = {4{64'h0123_4567_89ab_cdef}};
   localparam logic [95:0]  TAIL_C = 96'haabb_ccdd_eeff_0011_2233_4455;

   logic         clk = 1'b0;
   logic         reset;
   logic         start;
   logic         abort;
   logic [255:0] midstate;
   logic [95:0]  header_tail;
   logic [31:0]  nonce_start;
   logic [31:0]  nonce_end;
   logic [255:0] target;
   logic         busy;
   logic         done;
   logic         found;
   logic [31:0]  found_nonce;
   logic         error;
   logic [2:0]   state_dbg;
`ifdef MINER_HASH_CNT_EN
   logic [47:0]  hash_cnt;
`endif

   int total = 0;
   int bad   = 0;

   sha256_miner_if bus ();

   sha256_miner_ctrl dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .abort       (abort),
      .midstate    (midstate),
      .header_tail (header_tail),
      .nonce_start (nonce_start),
      .nonce_end   (nonce_end),
      .target      (target),
      .core        (bus),
      .busy        (busy),
      .done        (done),
      .found       (found),
      .found_nonce (found_nonce),
      .error       (error),
`ifdef MINER_HASH_CNT_EN
      .hash_cnt    (hash_cnt),
`endif
      .state_dbg   (state_dbg)
   );

   // clock
   always #5 clk = ~clk;

   // ---------------- behavioural core model ----------------
   int           model_lat  = 65;
   bit           model_mute = 1'b0;
   logic [31:0]  model_hit  = 32'hdead_beef;
   int           cnt_down   = 0;
   int           n_starts   = 0;
   int           n_dones    = 0;
   logic [255:0] pend       = '0;
   logic [31:0]  last_nonce = '0;
   logic [511:0] blk_q[$];
   logic [255:0] chn_q[$];

   function automatic logic [255:0] h1_of(input logic [31:0] n);
      return {8{n ^ 32'h5a5a_1234}};
   endfunction

   // Core model: sees core_start on the falling edge, answers model_lat cycles later.
   always @(negedge clk) begin
      bus.core_done = 1'b0;
      if (cnt_down > 0) begin
         cnt_down = cnt_down - 1;
         if (cnt_down == 0 && !model_mute) begin
            bus.core_done   = 1'b1;
            bus.core_digest = pend;
            n_dones = n_dones + 1;
         end
      end
      if (bus.core_start === 1'b1) begin
         n_starts = n_starts + 1;
         blk_q.push_back(bus.core_block);
         chn_q.push_back(bus.core_chain);
         if (bus.core_block[63:0] == 64'd640) begin
            last_nonce = bus.core_block[415:384];
            pend       = h1_of(last_nonce);
         end else begin
            pend = (last_nonce == model_hit) ? '0 : '1;
         end
         cnt_down = model_lat;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic drive_cfg(input logic [31:0] ns, input logic [31:0] ne, input logic [255:0] tgt);
      midstate    = MS_C;
      header_tail = TAIL_C;
      nonce_start = ns;
      nonce_end   = ne;
      target      = tgt;
      start       = 1'b1;
   endtask

   // Wait for done; cyc is the cycle count since start was raised, prev_st the state before done.
   task automatic wait_done(input string name, input int budget, output int cyc, output logic [2:0] prev_st);
      logic [2:0] ps;
      bit         seen;
      seen = 1'b0;
      ps   = 3'd0;
      cyc  = 0;
      for (int i = 0; i < budget && !seen; i++) begin
         step();
         start = 1'b0;
         cyc++;
         if (done === 1'b1) seen = 1'b1;
         else ps = state_dbg;
      end
      prev_st = ps;
      if (!seen) begin
         total++; bad++;
         $display("FAIL %s_done_timeout: done not seen within %0d cycles", name, budget);
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      reset = 1'b1; start = 1'b0; abort = 1'b0;
      midstate = '0; header_tail = '0; nonce_start = '0; nonce_end = '0; target = '0;
      idle(3);
      reset = 1'b0;
      step();
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
      total++; if ({done, found, error} !== 3'b000) begin bad++; $display("FAIL reset_flags: got %b want 000", {done, found, error}); end
      total++; if (found_nonce !== 32'd0) begin bad++; $display("FAIL reset_found_nonce: got %h want 0", found_nonce); end
      total++; if (bus.core_start !== 1'b0) begin bad++; $display("FAIL reset_core_start: got %b want 0", bus.core_start); end
      total++; if (bus.core_chain !== IV_C) begin bad++; $display("FAIL reset_core_chain: got %h want %h", bus.core_chain, IV_C); end
      total++; if (bus.core_block !== 512'd0) begin bad++; $display("FAIL reset_core_block: got %h want 0", bus.core_block); end
   endtask

   task automatic test_single_hit();
      int           base, cyc;
      logic [2:0]   ps;
      logic [511:0] exp_b1, exp_b2, b;
      model_lat = 65;
      model_hit = 32'hdead_beef;
      base = n_starts;
      drive_cfg(32'd5, 32'd20, '1);
      wait_done("hit", 400, cyc, ps);
      exp_b1 = {TAIL_C, 32'd5, 1'b1, 319'b0, 64'd640};
      exp_b2 = {h1_of(32'd5), 1'b1, 191'b0, 64'd256};
      total++; if (found !== 1'b1) begin bad++; $display("FAIL hit_found: got %b want 1", found); end
      total++; if (found_nonce !== 32'd5) begin bad++; $display("FAIL hit_nonce: got %h want 5", found_nonce); end
      total++; if (n_starts - base != 2) begin bad++; $display("FAIL hit_starts: got %0d want 2", n_starts - base); end
      total++; if (cyc != 134) begin bad++; $display("FAIL hit_latency: got %0d want 134", cyc); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL hit_busy_at_done: got %b want 0", busy); end
      if (n_starts - base >= 2) begin
         b = blk_q[base];
         total++; if (b[415:384] !== 32'd5) begin bad++; $display("FAIL hit_blk1_nonce: got %h want 5", b[415:384]); end
         total++; if (b[63:0] !== 64'd640) begin bad++; $display("FAIL hit_blk1_len: got %0d want 640", b[63:0]); end
         total++; if (b !== exp_b1) begin bad++; $display("FAIL hit_blk1: got %h want %h", b, exp_b1); end
         total++; if (chn_q[base] !== MS_C) begin bad++; $display("FAIL hit_chain1: got %h want %h", chn_q[base], MS_C); end
         total++; if (chn_q[base+1] !== IV_C) begin bad++; $display("FAIL hit_chain2: got %h want %h", chn_q[base+1], IV_C); end
         total++; if (blk_q[base+1] !== exp_b2) begin bad++; $display("FAIL hit_blk2: got %h want %h", blk_q[base+1], exp_b2); end
      end
      step();
      total++; if (done !== 1'b0) begin bad++; $display("FAIL hit_done_pulse: got %b want 0", done); end
      idle(80);
   endtask

   task automatic test_range_miss();
      int         base, cyc;
      logic [2:0] ps;
      model_lat = 65;
      base = n_starts;
      drive_cfg(32'h10, 32'h13, '0);
      wait_done("miss", 700, cyc, ps);
      total++; if (found !== 1'b0) begin bad++; $display("FAIL miss_found: got %b want 0", found); end
      total++; if (n_starts - base != 8) begin bad++; $display("FAIL miss_starts: got %0d want 8", n_starts - base); end
      total++; if (cyc != 533) begin bad++; $display("FAIL miss_latency: got %0d want 533", cyc); end
      total++; if (ps !== 3'd5) begin bad++; $display("FAIL miss_prev_check: got %0d want 5", ps); end
      total++; if (last_nonce !== 32'h13) begin bad++; $display("FAIL miss_last_nonce: got %h want 13", last_nonce); end
      idle(80);
   endtask

   task automatic test_wrap();
      int         base, cyc;
      logic [2:0] ps;
      model_lat = 10;
      model_hit = 32'h0;
      base = n_starts;
      drive_cfg(32'hffff_fffe, 32'h1, 256'd1);
      wait_done("wrap", 200, cyc, ps);
      total++; if (found !== 1'b1) begin bad++; $display("FAIL wrap_found: got %b want 1", found); end
      total++; if (found_nonce !== 32'h0) begin bad++; $display("FAIL wrap_nonce: got %h want 0", found_nonce); end
      total++; if (n_starts - base != 6) begin bad++; $display("FAIL wrap_starts: got %0d want 6", n_starts - base); end
      model_hit = 32'hdead_beef;
      idle(30);
   endtask

   task automatic test_abort();
      int  base, dbase;
      bit  fired;
      model_lat = 20;
      base  = n_starts;
      dbase = n_dones;
      fired = 1'b0;
      drive_cfg(32'h20, 32'h30, '0);
      for (int i = 0; i < 300 && !fired; i++) begin
         step();
         start = 1'b0;
         if (bus.core_done === 1'b1 && n_dones == dbase + 2) begin
            abort = 1'b1;
            fired = 1'b1;
         end
      end
      total++; if (!fired) begin bad++; $display("FAIL abort_sync: second core_done not seen got 0 want 1"); end
      step();
      abort = 1'b0;
      total++; if (done !== 1'b1) begin bad++; $display("FAIL abort_done: got %b want 1", done); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy: got %b want 0", busy); end
      total++; if (found !== 1'b0) begin bad++; $display("FAIL abort_found: got %b want 0", found); end
      idle(50);
      total++; if (n_starts - base != 2) begin bad++; $display("FAIL abort_no_restart: got %0d want 2", n_starts - base); end
      // abort mid-wait: the late core_done arrives in IDLE and must be ignored
      base = n_starts;
      drive_cfg(32'h20, 32'h30, '0);
      idle(5);
      start = 1'b0;
      abort = 1'b1;
      step();
      abort = 1'b0;
      total++; if (done !== 1'b1) begin bad++; $display("FAIL abort_mid_done: got %b want 1", done); end
      idle(40);
      total++; if ({busy, done} !== 2'b00) begin bad++; $display("FAIL abort_late_done: busy/done got %b want 00", {busy, done}); end
      total++; if (n_starts - base != 1) begin bad++; $display("FAIL abort_mid_starts: got %0d want 1", n_starts - base); end
   endtask

   task automatic test_timeout();
      int         c;
      bit         seen;
      int         cyc;
      logic [2:0] ps;
      model_mute = 1'b1;
      drive_cfg(32'h50, 32'h60, '1);
      seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
         step();
         start = 1'b0;
         if (bus.core_start === 1'b1) seen = 1'b1;
      end
      total++; if (!seen) begin bad++; $display("FAIL timeout_start: core_start got 0 want 1"); end
      c = 0;
      seen = 1'b0;
      for (int i = 0; i < 400 && !seen; i++) begin
         step();
         c++;
         if (error === 1'b1) seen = 1'b1;
      end
      total++; if (c != 256) begin bad++; $display("FAIL timeout_cycles: got %0d want 256", c); end
      total++; if (done !== 1'b1) begin bad++; $display("FAIL timeout_done: got %b want 1", done); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL timeout_busy: got %b want 0", busy); end
      model_mute = 1'b0;
      idle(80);
      model_lat = 6;
      drive_cfg(32'h50, 32'h60, '1);
      step();
      start = 1'b0;
      total++; if (error !== 1'b0) begin bad++; $display("FAIL timeout_clear: got %b want 0", error); end
      wait_done("timeout_rerun", 100, cyc, ps);
      total++; if ({found, error} !== 2'b10) begin bad++; $display("FAIL timeout_rerun: found/error got %b want 10", {found, error}); end
      idle(20);
   endtask

   task automatic test_start_busy();
      int         base, cyc;
      logic [2:0] ps;
      model_lat = 8;
      base = n_starts;
      drive_cfg(32'h40, 32'h41, '0);
      idle(4);
      drive_cfg(32'h99, 32'h99, '1);
      wait_done("start_busy", 100, cyc, ps);
      total++; if (found !== 1'b0) begin bad++; $display("FAIL start_busy_found: got %b want 0", found); end
      total++; if (n_starts - base != 4) begin bad++; $display("FAIL start_busy_starts: got %0d want 4", n_starts - base); end
      total++; if (last_nonce !== 32'h41) begin bad++; $display("FAIL start_busy_nonce: got %h want 41", last_nonce); end
      idle(20);
   endtask

   task automatic test_reset_mid();
      model_lat = 20;
      drive_cfg(32'h70, 32'h80, '0);
      idle(10);
      start = 1'b0;
      reset = 1'b1;
      step();
      reset = 1'b0;
      step();
      total++; if ({busy, done, found, error} !== 4'b0000) begin bad++; $display("FAIL reset_mid_flags: got %b want 0000", {busy, done, found, error}); end
      total++; if (bus.core_chain !== IV_C || bus.core_block !== 512'd0) begin bad++; $display("FAIL reset_mid_core: chain %h block %h want IV and 0", bus.core_chain, bus.core_block); end
      idle(30);
   endtask

`ifdef MINER_HASH_CNT_EN
   task automatic test_hash_cnt();
      int         cyc;
      logic [2:0] ps;
      model_lat = 4;
      drive_cfg(32'h100, 32'h107, '0);
      step();
      start = 1'b0;
      total++; if (hash_cnt !== 48'd0) begin bad++; $display("FAIL hash_cnt_clear: got %0d want 0", hash_cnt); end
      wait_done("hash_cnt", 200, cyc, ps);
      total++; if (hash_cnt !== 48'd8) begin bad++; $display("FAIL hash_cnt_value: got %0d want 8", hash_cnt); end
      idle(10);
   endtask
`endif

   initial begin
      test_reset();
      test_single_hit();
      test_range_miss();
      test_wrap();
      test_abort();
      test_timeout();
      test_start_busy();
      test_reset_mid();
`ifdef MINER_HASH_CNT_EN
      test_hash_cnt();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sha256_miner_ctrl.md
Name: sha256_miner_ctrl

Overview:
- Sequences one shared sha256 compression core through a double-SHA256 nonce search.
- Per nonce: hash1 = compress(midstate, block1(tail, nonce)); hash2 = compress(IV, block2(hash1)); compare hash2 against the target.
- Sits between the host configuration registers and the sha256 core. It owns the core's start/chain/block inputs and reports the found nonce, or exhaustion of the nonce range.

Parameters:
- TIMEOUT_CYCLES, 256, maximum cycles to wait for core_done after core_start before declaring a core error.
- TW, 9, width of the timeout counter; must satisfy 2^TW > TIMEOUT_CYCLES.

Ports:
- clk  in  1  single clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; latches config and begins search when idle
- abort  in  1  one-cycle pulse; stops the search
- midstate  in  256  chaining value after the first 64 header bytes
- header_tail  in  96  last 12 header bytes before the nonce
- nonce_start  in  32  first nonce tried
- nonce_end  in  32  last nonce tried (inclusive)
- target  in  256  unsigned threshold
- core_start  out  1  one-cycle start pulse to the core
- core_chain  out  256  chaining input to the core
- core_block  out  512  message block to the core
- core_done  in  1  one-cycle pulse; core_digest is valid in the same cycle
- core_digest  in  256  core result
- busy  out  1  search in progress
- done  out  1  one-cycle pulse at search end
- found  out  1  sticky until next start; the search ended on a hit
- found_nonce  out  32  nonce of the hit
- error  out  1  sticky until next start; core timeout occurred

Behaviour:
- Reset values: all outputs 0; core_chain = IV; core_block = 0; FSM = IDLE.
- Config latching: in IDLE, start latches all config inputs, clears found/error, and goes to H1_ISSUE. start while busy is ignored.
- block1 = {header_tail, nonce, 1'b1, 319'b0, 64'd640}, MSB first.
- block2 = {hash1, 1'b1, 191'b0, 64'd256}.
- No byte swapping is done in this block.
- State transitions:
  - H1_ISSUE: drive chain = midstate, block = block1, assert core_start for 1 cycle -> H1_WAIT.
  - H1_WAIT: on core_done, register hash1 -> H2_ISSUE.
  - H2_ISSUE: chain = IV, block = block2, core_start -> H2_WAIT.
  - H2_WAIT: on core_done, register hash2 -> CHECK.
  - CHECK: compare hash2 <= target as 256-bit unsigned.
    - Hit: found = 1, found_nonce = nonce, done pulse -> IDLE.
    - Miss with nonce == nonce_end: done pulse, found = 0 -> IDLE.
    - Otherwise: nonce += 1 (32-bit wrap) -> H1_ISSUE.
- Core input stability: core_chain and core_block stay stable from core_start until core_done.
- Nonce range: nonce_end < nonce_start is legal and wraps through 0xFFFFFFFF. nonce_start == nonce_end tries exactly one nonce.
- Per-nonce latency: 2 + 2 core latencies + 1 (CHECK) cycles.
- Timeout: the counter clears on every core_start. If it reaches TIMEOUT_CYCLES in a WAIT state: error = 1, done pulse -> IDLE.
- Abort: from any busy state, abort gives done pulse, found = 0 -> IDLE next cycle. Abort has priority over a same-cycle core_done and over a CHECK hit. Late core_done pulses in IDLE are ignored.
- busy = (state != IDLE). done is never asserted together with busy in the following cycle.
- Reset mid-search returns to IDLE with all outputs at reset values.

Optional Feature:
- Macro: MINER_HASH_CNT_EN.
- Defined: adds output hash_cnt[47:0], which counts completed CHECK evaluations, clears on start, and saturates at all-ones.
- Undefined: no port and no counter logic.

Decomposition:
- Package sha256_miner_pkg holds:
  - state enum typedef;
  - SHA256 IV constant (H0..H7);
  - padding constants for the 640-bit and 256-bit lengths;
  - block builder functions block1_f and block2_f.
- One sub-module, sha256_miner_cmp: registered 256-bit unsigned <= comparator, so the wide compare is isolated for timing. CHECK waits one cycle for its result.

Test Plan:
- Behavioural core model (latency 65), target = all-ones, nonce_start = 5 -> found = 1, found_nonce = 5, exactly 2 core_start pulses; first pulse has block[415:384] = 5 and block[63:0] = 640.
- target = 0, nonce_start = 0x10, nonce_end = 0x13 -> found = 0, 8 core_start pulses, done one cycle after the last CHECK.
- nonce_start = 0xFFFFFFFE, nonce_end = 0x1, model hits only at nonce 0x0 -> found_nonce = 0x00000000 after 3 nonces.
- abort asserted in the same cycle as the second core_done -> done pulse, found = 0, busy low next cycle, no further core_start.
- Model never returns core_done, TIMEOUT_CYCLES = 256 -> error = 1 exactly 256 cycles after core_start; a following start clears error.
- start re-pulsed while busy -> ignored, config unchanged. With MINER_HASH_CNT_EN and 8 nonces tried -> hash_cnt = 8.
